// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Optional two's-complement input, sign/magnitude result, sticky overflow.
module bin_to_bcd_seq #(
   parameter int LARGURA = 16,
   parameter int DIGITOS = 5
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   inicio,
   input  logic [LARGURA-1:0]     dado,
   input  logic                   com_sinal,
   output logic                   ocupado,
   output logic                   pronto,
   output logic [4*DIGITOS-1:0]   bcd,
   output logic                   negativo,
   output logic                   estouro
);

   localparam int CW = $clog2(LARGURA + 1);
   localparam int BW = 4 * DIGITOS;

   typedef enum logic {
      OCIOSO,
      CONVERTE
   } estado_t;

   estado_t            estado_q, estado_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [LARGURA-1:0] shr_q, shr_d;
   logic [BW-1:0]      dig_q, dig_d;
   logic               sinal_q, sinal_d;
   logic               ovf_q, ovf_d;
   logic [BW-1:0]      bcd_q, bcd_d;
   logic               neg_q, neg_d;
   logic               est_q, est_d;
   logic               pronto_q, pronto_d;

   logic               neg_in;
   logic [LARGURA-1:0] mag_in;
   logic [BW-1:0]      adj;
   logic [BW-1:0]      sh_dig;
   logic [LARGURA-1:0] sh_shr;
   logic               out_bit;

   assign neg_in = com_sinal & dado[LARGURA-1];
   assign mag_in = neg_in ? (-dado) : dado;

   // Add-3 correction on every working digit that is 5 or more
   always_comb begin
      adj = dig_q;
      for (int k = 0; k < DIGITOS; k++) begin
         if (dig_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
         end
      end
   end

   assign out_bit = adj[BW-1];
   assign sh_dig  = {adj[BW-2:0], shr_q[LARGURA-1]};
   assign sh_shr  = {shr_q[LARGURA-2:0], 1'b0};

   // Next-state: accept in idle, one shift step per cycle while converting
   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      shr_d    = shr_q;
      dig_d    = dig_q;
      sinal_d  = sinal_q;
      ovf_d    = ovf_q;
      bcd_d    = bcd_q;
      neg_d    = neg_q;
      est_d    = est_q;
      pronto_d = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            if (inicio) begin
               shr_d    = mag_in;
               dig_d    = '0;
               ovf_d    = 1'b0;
               cnt_d    = CW'(LARGURA);
               sinal_d  = neg_in & (mag_in != '0);
               estado_d = CONVERTE;
            end
         end
         CONVERTE: begin
            dig_d = sh_dig;
            shr_d = sh_shr;
            ovf_d = ovf_q | out_bit;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               bcd_d    = sh_dig;
               neg_d    = sinal_q;
               est_d    = ovf_q | out_bit;
               pronto_d = 1'b1;
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // State and result registers, cleared by asynchronous reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= OCIOSO;
         cnt_q    <= '0;
         shr_q    <= '0;
         dig_q    <= '0;
         sinal_q  <= 1'b0;
         ovf_q    <= 1'b0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
         est_q    <= 1'b0;
         pronto_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         shr_q    <= shr_d;
         dig_q    <= dig_d;
         sinal_q  <= sinal_d;
         ovf_q    <= ovf_d;
         bcd_q    <= bcd_d;
         neg_q    <= neg_d;
         est_q    <= est_d;
         pronto_q <= pronto_d;
      end
   end

   assign ocupado  = (estado_q == CONVERTE);
   assign pronto   = pronto_q;
   assign bcd      = bcd_q;
   assign negativo = neg_q;
   assign estouro  = est_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default, 4-digit and 8-bit instances.
// Vector table, handshake/reset sequences and random arithmetic model.
module tb_bin_to_bcd_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        inicio = 1'b0;
   logic [15:0] dado = '0;
   logic        com_sinal = 1'b0;
   logic        inicio8 = 1'b0;
   logic [7:0]  dado8 = '0;
   logic        s8 = 1'b0;

   logic        m_ocup, m_pronto, m_neg, m_est;
   logic [19:0] m_bcd;
   logic        d4_ocup, d4_pronto, d4_neg, d4_est;
   logic [15:0] d4_bcd;
   logic        e_ocup, e_pronto, e_neg, e_est;
   logic [11:0] e_bcd;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   bin_to_bcd_seq #(.LARGURA(16), .DIGITOS(5)) dut (
      .clock(clock), .reset_n(reset_n), .inicio(inicio), .dado(dado),
      .com_sinal(com_sinal), .ocupado(m_ocup), .pronto(m_pronto),
      .bcd(m_bcd), .negativo(m_neg), .estouro(m_est));

   bin_to_bcd_seq #(.LARGURA(16), .DIGITOS(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .inicio(inicio), .dado(dado),
      .com_sinal(com_sinal), .ocupado(d4_ocup), .pronto(d4_pronto),
      .bcd(d4_bcd), .negativo(d4_neg), .estouro(d4_est));

   bin_to_bcd_seq #(.LARGURA(8), .DIGITOS(3)) dut8 (
      .clock(clock), .reset_n(reset_n), .inicio(inicio8), .dado(dado8),
      .com_sinal(s8), .ocupado(e_ocup), .pronto(e_pronto),
      .bcd(e_bcd), .negativo(e_neg), .estouro(e_est));

   typedef struct {
      logic [15:0] d;
      bit          s;
      logic [19:0] b5;
      bit          n;
      bit          o5;
      logic [15:0] b4;
      bit          o4;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic void model(input longint unsigned d, input int w,
                                 input bit s, input int nd,
                                 output logic [19:0] b, output bit n,
                                 output bit o);
      longint unsigned m, p;
      m = d;
      n = 1'b0;
      if (s && ((d >> (w - 1)) & 1) == 1) begin
         m = (64'd1 << w) - d;
         n = (m != 0);
      end
      p = 1;
      b = '0;
      for (int k = 0; k < nd; k++) begin
         b[4*k +: 4] = 4'((m / p) % 10);
         p = p * 10;
      end
      o = (m >= p);
   endfunction

   task automatic conv16(input logic [15:0] d, input bit s,
                         input logic [19:0] eb, input bit en, input bit eo,
                         input logic [15:0] eb4, input bit eo4);
      int lat, busy;
      lat = 0;
      busy = 0;
      inicio = 1'b1;
      dado = d;
      com_sinal = s;
      @(posedge clock); #1;
      inicio = 1'b0;
      while (!m_pronto && lat < 40) begin
         if (m_ocup) busy++;
         @(posedge clock); #1;
         lat++;
      end
      chk("lat16", lat, 16);
      chk("busy16", busy, 16);
      chk("ocup_done", m_ocup, 0);
      chk("bcd5", m_bcd, eb);
      chk("neg5", m_neg, en);
      chk("ovf5", m_est, eo);
      chk("pronto4", d4_pronto, 1);
      chk("ocup4", d4_ocup, 0);
      chk("bcd4", d4_bcd, eb4);
      chk("neg4", d4_neg, en);
      chk("ovf4", d4_est, eo4);
      @(posedge clock); #1;
      chk("pulse16", m_pronto, 0);
   endtask

   task automatic conv8(input logic [7:0] d, input bit s,
                        input logic [11:0] eb, input bit en, input bit eo);
      int lat, busy;
      lat = 0;
      busy = 0;
      inicio8 = 1'b1;
      dado8 = d;
      s8 = s;
      @(posedge clock); #1;
      inicio8 = 1'b0;
      while (!e_pronto && lat < 40) begin
         if (e_ocup) busy++;
         @(posedge clock); #1;
         lat++;
      end
      chk("lat8", lat, 8);
      chk("busy8", busy, 8);
      chk("bcd8", e_bcd, eb);
      chk("neg8", e_neg, en);
      chk("ovf8", e_est, eo);
      @(posedge clock); #1;
      chk("pulse8", e_pronto, 0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[7];
      logic [19:0] b5, b4, b8;
      bit n, o5, o4, o8;
      logic [15:0] rd;
      logic [7:0] rd8;
      bit rs;
      int cnt, np;

      vt[0] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0, 1'b0, 16'h5535, 1'b1};
      vt[1] = '{16'h0000, 1'b0, 20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0};
      vt[2] = '{16'h8000, 1'b1, 20'h32768, 1'b1, 1'b0, 16'h2768, 1'b1};
      vt[3] = '{16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b0, 16'h0001, 1'b0};
      vt[4] = '{16'h7FFF, 1'b1, 20'h32767, 1'b0, 1'b0, 16'h2767, 1'b1};
      vt[5] = '{16'd12345, 1'b0, 20'h12345, 1'b0, 1'b0, 16'h2345, 1'b1};
      vt[6] = '{16'd9999, 1'b0, 20'h09999, 1'b0, 1'b0, 16'h9999, 1'b0};

      repeat (3) @(posedge clock);
      #1;
      chk("rst_ocup", m_ocup, 0);
      chk("rst_pronto", m_pronto, 0);
      chk("rst_bcd", m_bcd, 0);
      chk("rst_neg", m_neg, 0);
      chk("rst_ovf", m_est, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 7; i++) begin
         conv16(vt[i].d, vt[i].s, vt[i].b5, vt[i].n, vt[i].o5,
                vt[i].b4, vt[i].o4);
      end

      conv8(8'd255, 1'b0, 12'h255, 1'b0, 1'b0);
      conv8(8'h80, 1'b1, 12'h128, 1'b1, 1'b0);
      conv8(8'hFF, 1'b1, 12'h001, 1'b1, 1'b0);

      // handshake: ignored request while busy, back-to-back in pronto cycle
      inicio = 1'b1;
      dado = 16'd100;
      com_sinal = 1'b0;
      @(posedge clock); #1;
      inicio = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("hs_busy", m_ocup, 1);
      inicio = 1'b1;
      dado = 16'd200;
      @(posedge clock); #1;
      inicio = 1'b0;
      cnt = 0;
      while (!m_pronto && cnt < 40) begin
         @(posedge clock); #1;
         cnt++;
      end
      chk("hs_lat1", cnt, 12);
      chk("hs_bcd1", m_bcd, 20'h00100);
      inicio = 1'b1;
      dado = 16'd42;
      @(posedge clock); #1;
      inicio = 1'b0;
      cnt = 1;
      while (!m_pronto && cnt < 40) begin
         @(posedge clock); #1;
         cnt++;
      end
      chk("hs_lat2", cnt, 17);
      chk("hs_bcd2", m_bcd, 20'h00042);
      @(posedge clock); #1;
      chk("hs_pulse", m_pronto, 0);

      // reset in the middle of a conversion
      inicio = 1'b1;
      dado = 16'hFFFF;
      @(posedge clock); #1;
      inicio = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_ocup", m_ocup, 0);
      chk("mid_pronto", m_pronto, 0);
      chk("mid_bcd", m_bcd, 0);
      chk("mid_neg", m_neg, 0);
      chk("mid_ovf", m_est, 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      np = 0;
      repeat (20) begin
         @(posedge clock); #1;
         if (m_pronto) np++;
      end
      chk("mid_nopronto", np, 0);
      chk("mid_idle", m_ocup, 0);
      conv16(16'd500, 1'b0, 20'h00500, 1'b0, 1'b0, 16'h0500, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rd = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         model(rd, 16, rs, 5, b5, n, o5);
         model(rd, 16, rs, 4, b4, n, o4);
         conv16(rd, rs, b5, n, o5, b4[15:0], o4);
      end
      for (int i = 0; i < 10; i++) begin
         rd8 = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         model(rd8, 8, rs, 3, b8, n, o8);
         conv8(rd8, rs, b8[11:0], n, o8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
